// File: rtl/image_compositor_pkg.sv
// Shared types and constants for the image compositor: pipeline region tags,
// colour constants and the selection-cursor move encoding.
package image_compositor_pkg;

    typedef enum logic [2:0] {OUTSIDE, BG, IMG1, IMG1_BORDER, IMG2} region_t;

    typedef enum logic [1:0] {NONE, NEG, POS} move_t;

    typedef enum logic {IDLE, PENDING} cursor_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t C_WHITE = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
    localparam rgb_t C_RED   = '{r: 8'hFF, g: 8'h00, b: 8'h00};
    localparam rgb_t C_BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};

    // Opposing requests in the same cycle cancel the axis; otherwise the newest wins.
    function automatic move_t axis_request(input logic neg, input logic pos, input move_t cur);
        if (neg && pos) return NONE;
        if (neg)        return NEG;
        if (pos)        return POS;
        return cur;
    endfunction

endpackage

// File: rtl/image_compositor_selection_cursor.sv
// Selection-square cursor: collects button moves per axis and applies at most
// one clamped step per axis at the next frame boundary.
module selection_cursor
    import image_compositor_pkg::*;
#(
    parameter int IMG1_W   = 400,
    parameter int IMG1_H   = 400,
    parameter int SEL_SIZE = 100,
    parameter int SEL_STEP = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       btn_up,
    input  logic       btn_dn,
    input  logic       btn_lf,
    input  logic       btn_rt,
    output logic [8:0] sel_x,
    output logic [8:0] sel_y
);

    localparam int MAX_X = IMG1_W - SEL_SIZE;
    localparam int MAX_Y = IMG1_H - SEL_SIZE;

    cursor_state_t state, state_nxt;
    move_t         pend_x, pend_y, pend_x_nxt, pend_y_nxt;
    move_t         base_x, base_y;
    logic [8:0]    sel_x_nxt, sel_y_nxt;
    logic          apply;
    logic          any_btn;

    function automatic logic [8:0] step_pos(input logic [8:0] pos, input move_t mv, input int max_pos);
        int p;
        p = int'(pos);
        case (mv)
            POS:     p = (p + SEL_STEP > max_pos) ? max_pos : p + SEL_STEP;
            NEG:     p = (p < SEL_STEP) ? 0 : p - SEL_STEP;
            default: p = int'(pos);
        endcase
        return p[8:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pend_x <= NONE;
            pend_y <= NONE;
            sel_x  <= '0;
            sel_y  <= '0;
        end else begin
            state  <= state_nxt;
            pend_x <= pend_x_nxt;
            pend_y <= pend_y_nxt;
            sel_x  <= sel_x_nxt;
            sel_y  <= sel_y_nxt;
        end
    end

    // Pulses arriving with frame_start are folded in after the clear, so they wait a frame.
    always_comb begin
        apply      = frame_start && (state == PENDING);
        any_btn    = btn_up || btn_dn || btn_lf || btn_rt;
        sel_x_nxt  = sel_x;
        sel_y_nxt  = sel_y;
        state_nxt  = state;
        base_x     = pend_x;
        base_y     = pend_y;
        if (apply) begin
            sel_x_nxt = step_pos(sel_x, pend_x, MAX_X);
            sel_y_nxt = step_pos(sel_y, pend_y, MAX_Y);
            base_x    = NONE;
            base_y    = NONE;
            state_nxt = IDLE;
        end
        pend_x_nxt = axis_request(btn_lf, btn_rt, base_x);
        pend_y_nxt = axis_request(btn_up, btn_dn, base_y);
        if (any_btn) begin
            state_nxt = PENDING;
        end
    end

endmodule

// File: rtl/image_compositor.sv
// Pipelined VGA image compositor: beam position -> frame-buffer address -> RGB,
// with a selection-square overlay on image 1. Optional border blink: SEL_BLINK_EN.
module image_compositor
    import image_compositor_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int IMG1_X     = 0,
    parameter int IMG1_Y     = 0,
    parameter int IMG1_W     = 400,
    parameter int IMG1_H     = 400,
    parameter int IMG2_X     = 439,
    parameter int IMG2_Y     = 0,
    parameter int IMG2_W     = 200,
    parameter int IMG2_H     = 200,
    parameter int ADDR_W     = 19,
    parameter int PIX_W      = 8,
    parameter int MEM_LAT    = 2,
    parameter int SEL_SIZE   = 100,
    parameter int SEL_BORDER = 1,
    parameter int SEL_STEP   = 100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        hs,
    input  logic [9:0]        vs,
    input  logic              frame_start,
    input  logic              btn_up,
    input  logic              btn_dn,
    input  logic              btn_lf,
    input  logic              btn_rt,
    input  logic [PIX_W-1:0]  pixel,
    output logic [ADDR_W-1:0] memory_addr,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic              pix_valid,
    output logic [8:0]        sel_x,
    output logic [8:0]        sel_y
);

    localparam logic [ADDR_W-1:0] HA        = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0] VA        = ADDR_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] I1X       = ADDR_W'(IMG1_X);
    localparam logic [ADDR_W-1:0] I1Y       = ADDR_W'(IMG1_Y);
    localparam logic [ADDR_W-1:0] I1W       = ADDR_W'(IMG1_W);
    localparam logic [ADDR_W-1:0] I1H       = ADDR_W'(IMG1_H);
    localparam logic [ADDR_W-1:0] I2X       = ADDR_W'(IMG2_X);
    localparam logic [ADDR_W-1:0] I2Y       = ADDR_W'(IMG2_Y);
    localparam logic [ADDR_W-1:0] I2W       = ADDR_W'(IMG2_W);
    localparam logic [ADDR_W-1:0] I2H       = ADDR_W'(IMG2_H);
    localparam logic [ADDR_W-1:0] SS        = ADDR_W'(SEL_SIZE);
    localparam logic [ADDR_W-1:0] SB        = ADDR_W'(SEL_BORDER);
    localparam logic [ADDR_W-1:0] IMG2_BASE = ADDR_W'(IMG1_W * IMG1_H);

    logic [ADDR_W-1:0] hs_e, vs_e, dx1, dy1, dx2, dy2, sdx, sdy, addr_a;
    logic              in_active, in_img1, in_img2, in_square, on_edge;
    logic              border_on;
    region_t           region_a;
    region_t           tag_d [MEM_LAT];
    logic [7:0]        grey;
    rgb_t              colour_nxt;
    logic              valid_nxt;

    selection_cursor #(
        .IMG1_W   (IMG1_W),
        .IMG1_H   (IMG1_H),
        .SEL_SIZE (SEL_SIZE),
        .SEL_STEP (SEL_STEP)
    ) u_cursor (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .btn_up      (btn_up),
        .btn_dn      (btn_dn),
        .btn_lf      (btn_lf),
        .btn_rt      (btn_rt),
        .sel_x       (sel_x),
        .sel_y       (sel_y)
    );

`ifdef SEL_BLINK_EN
    logic [5:0] blink_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
        end else if (frame_start) begin
            blink_cnt <= blink_cnt + 6'd1;
        end
    end

    assign border_on = ~blink_cnt[5];
`else
    assign border_on = 1'b1;
`endif

    // Range tests use unsigned wrap: (v - lo) < len covers lo <= v < lo+len.
    always_comb begin
        hs_e      = ADDR_W'(hs);
        vs_e      = ADDR_W'(vs);
        dx1       = hs_e - I1X;
        dy1       = vs_e - I1Y;
        dx2       = hs_e - I2X;
        dy2       = vs_e - I2Y;
        sdx       = dx1 - ADDR_W'(sel_x);
        sdy       = dy1 - ADDR_W'(sel_y);
        in_active = (hs_e < HA) && (vs_e < VA);
        in_img1   = (dx1 < I1W) && (dy1 < I1H);
        in_img2   = (dx2 < I2W) && (dy2 < I2H);
        in_square = (sdx < SS) && (sdy < SS);
        on_edge   = (sdx < SB) || (sdx >= SS - SB) || (sdy < SB) || (sdy >= SS - SB);
        region_a  = OUTSIDE;
        addr_a    = '0;
        if (in_active) begin
            if (in_img1) begin
                region_a = (in_square && on_edge && border_on) ? IMG1_BORDER : IMG1;
                addr_a   = dx1 + dy1 * I1W;
            end else if (in_img2) begin
                region_a = IMG2;
                addr_a   = IMG2_BASE + dx2 + dy2 * I2W;
            end else begin
                region_a = BG;
            end
        end
    end

    // Tags clear to OUTSIDE so nothing stale reaches the output after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memory_addr <= '0;
            for (int i = 0; i < MEM_LAT; i++) tag_d[i] <= OUTSIDE;
        end else begin
            memory_addr <= addr_a;
            tag_d[0]    <= region_a;
            for (int i = 1; i < MEM_LAT; i++) tag_d[i] <= tag_d[i-1];
        end
    end

    generate
        if (PIX_W >= 8) begin : g_grey_msb
            assign grey = pixel[PIX_W-1 -: 8];
        end else begin : g_grey_pad
            assign grey = {{(8-PIX_W){1'b0}}, pixel};
        end
    endgenerate

    always_comb begin
        colour_nxt = C_BLACK;
        valid_nxt  = 1'b0;
        case (tag_d[MEM_LAT-1])
            BG: begin
                colour_nxt = C_WHITE;
                valid_nxt  = 1'b1;
            end
            IMG1, IMG2: begin
                colour_nxt = '{r: grey, g: grey, b: grey};
                valid_nxt  = 1'b1;
            end
            IMG1_BORDER: begin
                colour_nxt = C_RED;
                valid_nxt  = 1'b1;
            end
            default: begin
                colour_nxt = C_BLACK;
                valid_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            pix_valid <= 1'b0;
        end else begin
            red       <= colour_nxt.r;
            green     <= colour_nxt.g;
            blue      <= colour_nxt.b;
            pix_valid <= valid_nxt;
        end
    end

endmodule
